// File: rtl/fetch_pc_unit.sv
// PC register and instruction-fetch sequencer with squash of stale in-flight fetches.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned redirects into a HALT state.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [31:0] EX_MEM_PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] IF_ID_IR,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_NPC,
  output logic        misalign_err
);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_FETCH, S_FULL, S_DRAIN, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_FETCH, S_FULL, S_DRAIN} state_t;
`endif

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_q;
  logic [31:0] ir_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_npc_q;
  logic        valid_q;

  logic [31:0] pc_plus4_d;
  logic [31:0] target_d;

  assign pc_plus4_d = pc_q + 32'd4;
  assign target_d   = EX_MEM_PC & 32'hFFFF_FFFC;

`ifdef MISALIGN_TRAP_EN
  logic err_q;
  logic halt_pend_q;
  logic misaligned_d;
  assign misaligned_d = redirect_en && (EX_MEM_PC[1:0] != 2'b00);
  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif

  // The request address is always pc_q: in DRAIN the new target waits in pend_q.
  assign imem_req  = !rst && (state_q == S_FETCH || state_q == S_DRAIN);
  assign imem_addr = pc_q;
  assign if_valid  = valid_q;
  assign IF_ID_IR  = ir_q;
  assign IF_ID_PC  = id_pc_q;
  assign IF_ID_NPC = id_npc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      pend_q   <= RESET_PC;
      ir_q     <= NOP_INSTR;
      id_pc_q  <= RESET_PC;
      id_npc_q <= RESET_PC + 32'd4;
      valid_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      err_q       <= 1'b0;
      halt_pend_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_FETCH: begin
`ifdef MISALIGN_TRAP_EN
          if (misaligned_d) begin
            err_q <= 1'b1;
            if (imem_ack) begin
              state_q <= S_HALT;
            end else begin
              halt_pend_q <= 1'b1;
              state_q     <= S_DRAIN;
            end
          end else
`endif
          if (redirect_en) begin
            if (imem_ack) begin
              pc_q <= target_d;
            end else begin
              pend_q  <= target_d;
              state_q <= S_DRAIN;
            end
          end else if (imem_ack) begin
            ir_q     <= imem_rdata;
            id_pc_q  <= pc_q;
            id_npc_q <= pc_plus4_d;
            valid_q  <= 1'b1;
            pc_q     <= pc_plus4_d;
            state_q  <= S_FULL;
          end
        end
        S_DRAIN: begin
`ifdef MISALIGN_TRAP_EN
          // A trap already taken only waits for the outstanding ack.
          if (halt_pend_q) begin
            if (imem_ack) state_q <= S_HALT;
          end else if (misaligned_d) begin
            err_q <= 1'b1;
            if (imem_ack) state_q <= S_HALT;
            else halt_pend_q <= 1'b1;
          end else
`endif
          if (redirect_en) begin
            if (imem_ack) begin
              pc_q    <= target_d;
              state_q <= S_FETCH;
            end else begin
              pend_q <= target_d;
            end
          end else if (imem_ack) begin
            pc_q    <= pend_q;
            state_q <= S_FETCH;
          end
        end
        S_FULL: begin
`ifdef MISALIGN_TRAP_EN
          if (misaligned_d) begin
            err_q   <= 1'b1;
            valid_q <= 1'b0;
            state_q <= S_HALT;
          end else
`endif
          if (redirect_en) begin
            valid_q <= 1'b0;
            pc_q    <= target_d;
            state_q <= S_FETCH;
          end else if (id_ready) begin
            valid_q <= 1'b0;
            state_q <= S_FETCH;
          end
        end
`ifdef MISALIGN_TRAP_EN
        S_HALT: state_q <= S_HALT;
`endif
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule
